// File: rtl/fp_stream_max.sv
// Framed running-maximum reduction over 13-bit sign-magnitude floats.
// Emits {max, index, count, trunc} as one result beat per frame.

module fp13_gt (
    input  logic [12:0] fp1,
    input  logic [12:0] fp2,
    output logic        gt
);
    logic [11:0] mag1;
    logic [11:0] mag2;

    always_comb begin
        mag1 = fp1[11:0];
        mag2 = fp2[11:0];
        gt   = 1'b0;
        if (fp1[12] != fp2[12]) begin
            gt = ~fp1[12];
        end else if (!fp1[12]) begin
            gt = mag1 > mag2;
        end else begin
            gt = mag1 < mag2;
        end
    end
endmodule

// state | meaning
// ACCUM | accepting samples, tracking running max/index
// HOLD  | result beat presented, waiting for out_ready
module fp_stream_max #(
    parameter int IDX_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [12:0]      in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [12:0]      out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_count,
    output logic             out_trunc,
    output logic             out_valid,
    input  logic             out_ready
);
    typedef enum logic {ACCUM, HOLD} state_t;

    state_t           state;
    logic [12:0]      run_max;
    logic [IDX_W-1:0] run_idx;
    logic [IDX_W-1:0] count;
    logic             gt;
    logic             accept;
    logic             first;
    logic             frame_end;
    logic [12:0]      new_max;
    logic [IDX_W-1:0] new_idx;

    fp13_gt u_gt (
        .fp1 (in_data),
        .fp2 (run_max),
        .gt  (gt)
    );

    // Ties leave the stored max alone so the earliest occurrence keeps its index.
    always_comb begin
        accept    = in_valid & in_ready;
        first     = (count == '0);
        frame_end = in_last | (&count);
        new_max   = run_max;
        new_idx   = run_idx;
        if (first) begin
            new_max = in_data;
            new_idx = '0;
        end else if (gt) begin
            new_max = in_data;
            new_idx = count;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ACCUM;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_max   <= '0;
            out_idx   <= '0;
            out_count <= '0;
            out_trunc <= 1'b0;
            run_max   <= '0;
            run_idx   <= '0;
            count     <= '0;
        end else begin
            case (state)
                ACCUM: begin
                    if (accept) begin
                        run_max <= new_max;
                        run_idx <= new_idx;
                        if (frame_end) begin
                            out_max   <= new_max;
                            out_idx   <= new_idx;
                            out_count <= (IDX_W+1)'(count) + (IDX_W+1)'(1);
                            out_trunc <= ~in_last;
                            out_valid <= 1'b1;
                            in_ready  <= 1'b0;
                            count     <= '0;
                            state     <= HOLD;
                        end else begin
                            count <= count + IDX_W'(1);
                        end
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ACCUM;
                    end
                end
                default: begin
                    state     <= ACCUM;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
